// File: rtl/boot_stream_loader.sv
// Purpose: receive a framed program image over a data/strobe pin pair and emit one memory write per payload word.
// Latency: wr_en rises 2 clk after the synchronised strobe edge that carries the last bit of a payload word.
// Backpressure: none; the host sets the pace, and words that arrive in DONE or ERROR are dropped until rx_en falls.
module boot_stream_loader #(
    parameter int WORD_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int SYNC_STAGES    = 2,
    parameter int CHECKSUM_EN    = 1,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_en,
    input  logic                  data_pin,
    input  logic                  strobe_pin,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [WORD_WIDTH-1:0] wr_data,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_WIDTH:0]   words_loaded
);

    localparam int BCW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int ICW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [BCW-1:0]      LAST_BIT  = BCW'(WORD_WIDTH - 1);
    localparam logic [ICW-1:0]      IDLE_MAX  = ICW'(TIMEOUT_CYCLES);
    localparam logic [WORD_WIDTH:0] MAX_WORDS = (WORD_WIDTH + 1)'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CHECK,
        S_DONE,
        S_ERROR
    } state_t;

    // ---------------- input synchronisers ----------------
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [SYNC_STAGES-1:0] strobe_sync_q;
    logic                   strobe_prev_q;
    logic                   data_s;
    logic                   strobe_s;
    logic                   strobe_edge;

    assign data_s      = data_sync_q[SYNC_STAGES-1];
    assign strobe_s    = strobe_sync_q[SYNC_STAGES-1];
    assign strobe_edge = strobe_s & ~strobe_prev_q;

    // Both pins go through identical chains so data and strobe stay aligned.
    always_ff @(posedge clk) begin
        if (reset) begin
            data_sync_q   <= '0;
            strobe_sync_q <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            data_sync_q   <= {data_sync_q[SYNC_STAGES-2:0], data_pin};
            strobe_sync_q <= {strobe_sync_q[SYNC_STAGES-2:0], strobe_pin};
            strobe_prev_q <= strobe_s;
        end
    end

    // ---------------- bit receiver ----------------
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] word_q, word_d;
    logic                  word_vld_q, word_vld_d;
    logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
    logic [ICW-1:0]        idle_q, idle_d;

    // Shift bits in MSB first, flag complete words, and drop a stalled partial word.
    always_comb begin
        shift_d    = shift_q;
        word_d     = word_q;
        word_vld_d = 1'b0;
        bit_cnt_d  = bit_cnt_q;
        idle_d     = idle_q;
        if (!rx_en) begin
            shift_d   = '0;
            bit_cnt_d = '0;
            idle_d    = '0;
        end else if (strobe_edge) begin
            shift_d = {shift_q[WORD_WIDTH-2:0], data_s};
            idle_d  = '0;
            if (bit_cnt_q == LAST_BIT) begin
                bit_cnt_d  = '0;
                word_vld_d = 1'b1;
                word_d     = {shift_q[WORD_WIDTH-2:0], data_s};
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != '0) begin
            // A host that stalls mid-word is assumed to restart on a word boundary.
            if (idle_q == IDLE_MAX) begin
                shift_d   = '0;
                bit_cnt_d = '0;
                idle_d    = '0;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    // Receiver registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q    <= '0;
            word_q     <= '0;
            word_vld_q <= 1'b0;
            bit_cnt_q  <= '0;
            idle_q     <= '0;
        end else begin
            shift_q    <= shift_d;
            word_q     <= word_d;
            word_vld_q <= word_vld_d;
            bit_cnt_q  <= bit_cnt_d;
            idle_q     <= idle_d;
        end
    end

    // ---------------- frame FSM ----------------
    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WORD_WIDTH-1:0] checksum_q, checksum_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [WORD_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [ADDR_WIDTH:0]   words_loaded_q, words_loaded_d;
    logic                  hdr_oversize;
    logic                  hdr_zero;
    logic                  cks_en;

    assign hdr_oversize = {1'b0, word_q} > MAX_WORDS;
    assign hdr_zero     = (word_q == '0);
    assign cks_en       = (CHECKSUM_EN != 0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state: rx_en low aborts to IDLE, otherwise advance on each received word.
    always_comb begin
        state_d = state_q;
        if (!rx_en) begin
            state_d = S_IDLE;
        end else if (word_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    if (hdr_oversize)  state_d = S_ERROR;
                    else if (hdr_zero) state_d = cks_en ? S_CHECK : S_DONE;
                    else               state_d = S_LOAD;
                end
                S_LOAD: begin
                    if (remaining_q == (ADDR_WIDTH + 1)'(1))
                        state_d = cks_en ? S_CHECK : S_DONE;
                end
                S_CHECK: state_d = (word_q == checksum_q) ? S_DONE : S_ERROR;
                default: state_d = state_q;
            endcase
        end
    end

    // Outputs and frame datapath: header setup, write issue, checksum accumulate, status.
    always_comb begin
        remaining_d    = remaining_q;
        addr_d         = addr_q;
        checksum_d     = checksum_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        done_d         = done_q;
        error_d        = error_q;
        words_loaded_d = words_loaded_q;
        if (rx_en && word_vld_q) begin
            case (state_q)
                S_IDLE: begin
                    done_d         = 1'b0;
                    error_d        = 1'b0;
                    words_loaded_d = '0;
                    checksum_d     = '0;
                    addr_d         = '0;
                    wr_addr_d      = '0;
                    remaining_d    = word_q[ADDR_WIDTH:0];
                    if (hdr_oversize)            error_d = 1'b1;
                    else if (hdr_zero && !cks_en) done_d = 1'b1;
                end
                S_LOAD: begin
                    wr_en_d        = 1'b1;
                    wr_addr_d      = addr_q;
                    wr_data_d      = word_q;
                    addr_d         = addr_q + 1'b1;
                    words_loaded_d = words_loaded_q + 1'b1;
                    checksum_d     = checksum_q + word_q;
                    remaining_d    = remaining_q - 1'b1;
                    if (remaining_q == (ADDR_WIDTH + 1)'(1) && !cks_en) done_d = 1'b1;
                end
                S_CHECK: begin
                    if (word_q == checksum_q) done_d  = 1'b1;
                    else                      error_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q    <= '0;
            addr_q         <= '0;
            checksum_q     <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            words_loaded_q <= '0;
        end else begin
            remaining_q    <= remaining_d;
            addr_q         <= addr_d;
            checksum_q     <= checksum_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            done_q         <= done_d;
            error_q        <= error_d;
            words_loaded_q <= words_loaded_d;
        end
    end

    assign wr_en        = wr_en_q;
    assign wr_addr      = wr_addr_q;
    assign wr_data      = wr_data_q;
    assign busy         = (state_q == S_LOAD) || (state_q == S_CHECK);
    assign done         = done_q;
    assign error        = error_q;
    assign words_loaded = words_loaded_q;

endmodule
